// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED display stage.
// State encoding is fixed; the unused code 2'd3 falls back to SHOW.
package led_drv_pkg;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    FLASH = 2'd1,
    CHASE = 2'd2
  } state_e;

  localparam logic [3:0] LED_ALL_ON  = 4'hF;
  localparam logic [3:0] CHASE_START = 4'b0001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with brightness compare; all-ones brightness
// forces the output fully on so the top code is not lost to the wrap.
module led_pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                CLK_IN,
  input  logic                CPU_RESETN,
  input  logic [PWM_BITS-1:0] bright_in,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
    if (CPU_RESETN) pwm_cnt_q <= '0;
    else            pwm_cnt_q <= pwm_cnt_d;
  end

  assign pwm_on = (pwm_cnt_q < bright_in) || (&bright_in);

endmodule

// File: rtl/led_pattern_driver.sv
// Display stage for the button counter: PWM-dimmed count, a full-on flash
// per press and a one-hot chase when the count wraps 15 -> 0.
module led_pattern_driver
  import led_drv_pkg::*;
#(
  parameter int PWM_BITS          = 4,
  parameter int FLASH_CYCLES      = 1000,
  parameter int CHASE_STEP_CYCLES = 2000,
  parameter int CHASE_LAPS        = 2
) (
  input  logic                CLK_IN,
  input  logic                CPU_RESETN,
  input  logic [3:0]          count_in,
  input  logic                count_stb,
  input  logic [PWM_BITS-1:0] bright_in,
  output logic [3:0]          leds,
  output logic                busy
);

  localparam int TW = $clog2(max_int(FLASH_CYCLES, CHASE_STEP_CYCLES) + 1);
  localparam int LW = $clog2(CHASE_LAPS + 1);

  localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LOAD  = TW'(CHASE_STEP_CYCLES - 1);
  localparam logic [LW-1:0] LAPS       = LW'(CHASE_LAPS);

  state_e        state_q, state_d;
  logic [3:0]    value_q, value_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pos_q,   pos_d;
  logic [LW-1:0] lap_q,   lap_d;
  logic [3:0]    leds_q,  leds_d;
  logic          busy_q,  busy_d;
  logic          pwm_on;
  logic          wrap;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .CLK_IN     (CLK_IN),
    .CPU_RESETN (CPU_RESETN),
    .bright_in  (bright_in),
    .pwm_on     (pwm_on)
  );

  // Old stored value against the incoming one: a real 15 -> 0 roll-over.
  assign wrap = count_stb && (value_q == 4'hF) && (count_in == 4'h0);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_d   = pos_q;
    lap_d   = lap_q;
    value_d = count_stb ? count_in : value_q;
    busy_d  = (state_q != SHOW);

    case (state_q)
      SHOW:    leds_d = value_q & {4{pwm_on}};
      FLASH:   leds_d = LED_ALL_ON;
      CHASE:   leds_d = pos_q;
      default: leds_d = '0;
    endcase

    if (wrap) begin
      state_d = CHASE;
      pos_d   = CHASE_START;
      lap_d   = '0;
      timer_d = STEP_LOAD;
    end else if (count_stb && (state_q == SHOW || state_q == FLASH)) begin
      state_d = FLASH;
      timer_d = FLASH_LOAD;
    end else begin
      case (state_q)
        SHOW: state_d = SHOW;
        FLASH: begin
          if (timer_q == '0) state_d = SHOW;
          else               timer_d = timer_q - 1'b1;
        end
        CHASE: begin
          if (timer_q == '0) begin
            pos_d   = {pos_q[2:0], pos_q[3]};
            timer_d = STEP_LOAD;
            // A lap ends when the last LED's step expires.
            if (pos_q[3]) begin
              lap_d = lap_q + 1'b1;
              if (lap_d == LAPS) state_d = SHOW;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = SHOW;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or posedge CPU_RESETN) begin
    if (CPU_RESETN) begin
      state_q <= SHOW;
      value_q <= '0;
      timer_q <= '0;
      pos_q   <= CHASE_START;
      lap_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      lap_q   <= lap_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver: expected per-cycle LED/busy values
// are queued as stimulus is applied and compared at each falling edge.
module tb_led_pattern_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = 4'h0;
  logic       count_stb = 1'b0;
  logic [3:0] bright_in = 4'hF;
  logic [3:0] leds;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] leds;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  led_pattern_driver #(
    .PWM_BITS          (4),
    .FLASH_CYCLES      (4),
    .CHASE_STEP_CYCLES (3),
    .CHASE_LAPS        (1)
  ) dut (
    .CLK_IN     (clk),
    .CPU_RESETN (rst),
    .count_in   (count_in),
    .count_stb  (count_stb),
    .bright_in  (bright_in),
    .leds       (leds),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] l, input logic b, input int n);
    exp_t e;
    e.leds = l;
    e.busy = b;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check({tag, "_leds"}, 8'(leds), 8'(e.leds));
      check({tag, "_busy"}, 8'(busy), 8'(e.busy));
    end
  endtask

  // Drive a one-cycle strobe; returns at the falling edge after it was sampled.
  task automatic strobe(input logic [3:0] val);
    count_in  = val;
    count_stb = 1'b1;
    @(negedge clk);
    count_stb = 1'b0;
  endtask

  task automatic push_chase_lap();
    push(4'b0001, 1'b1, 3);
    push(4'b0010, 1'b1, 3);
    push(4'b0100, 1'b1, 3);
    push(4'b1000, 1'b1, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int on_cnt;
    int off_cnt;

    // Reset state
    push(4'h0, 1'b0, 2);
    drain("reset");
    rst = 1'b0;
    push(4'h0, 1'b0, 3);
    drain("post_reset");

    // 1: press -> 4-cycle flash, then count shown at full brightness
    strobe(4'h5);
    push(4'hF, 1'b1, 4);
    push(4'h5, 1'b0, 4);
    drain("flash_basic");

    // 2: PWM duty at bright=4, then bright=0
    bright_in = 4'h4;
    strobe(4'hA);
    push(4'hF, 1'b1, 4);
    drain("flash_a");
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (leds === 4'hA) on_cnt++;
      else if (leds === 4'h0) off_cnt++;
    end
    check("pwm_on_cycles", 8'(on_cnt), 8'd4);
    check("pwm_off_cycles", 8'(off_cnt), 8'd12);
    bright_in = 4'h0;
    push(4'h0, 1'b0, 8);
    drain("pwm_dark");

    // 3: wrap F -> 0 starts the chase
    bright_in = 4'hF;
    strobe(4'hF);
    push(4'hF, 1'b1, 4);
    push(4'hF, 1'b0, 1);
    drain("pre_wrap");
    strobe(4'h0);
    push_chase_lap();
    push(4'h0, 1'b0, 2);
    drain("chase");

    // 4a: retrigger two clocks into a flash
    strobe(4'h3);
    push(4'hF, 1'b1, 1);
    drain("flash_first");
    strobe(4'h7);
    push(4'hF, 1'b1, 4);
    push(4'h7, 1'b0, 2);
    drain("flash_retrig");

    // 4b: non-wrap press during chase only updates the stored value
    strobe(4'hF);
    push(4'hF, 1'b1, 4);
    push(4'hF, 1'b0, 1);
    drain("pre_wrap2");
    strobe(4'h0);
    push(4'b0001, 1'b1, 1);
    drain("chase2_start");
    strobe(4'h9);
    push(4'b0001, 1'b1, 1);
    push(4'b0010, 1'b1, 3);
    push(4'b0100, 1'b1, 3);
    push(4'b1000, 1'b1, 3);
    push(4'h9, 1'b0, 2);
    drain("chase2_rest");

    // 5: asynchronous reset in the middle of a chase
    strobe(4'hF);
    push(4'hF, 1'b1, 4);
    push(4'hF, 1'b0, 1);
    drain("pre_wrap3");
    strobe(4'h0);
    push(4'b0001, 1'b1, 3);
    push(4'b0010, 1'b1, 1);
    drain("chase3_start");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_leds", 8'(leds), 8'h00);
    check("async_rst_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    push(4'h0, 1'b0, 2);
    drain("after_rst");
    strobe(4'h2);
    push(4'hF, 1'b1, 4);
    push(4'h2, 1'b0, 2);
    drain("flash_after_rst");

    // 6: E -> F is not a wrap; F -> 0 is
    strobe(4'hE);
    push(4'hF, 1'b1, 4);
    push(4'hE, 1'b0, 1);
    drain("flash_e");
    strobe(4'hF);
    push(4'hF, 1'b1, 4);
    push(4'hF, 1'b0, 1);
    drain("no_wrap_ef");
    strobe(4'h0);
    push_chase_lap();
    push(4'h0, 1'b0, 2);
    drain("wrap_f0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
